// File: rtl/mem_burst_arbiter_if.sv
// Bus bundle between the video channel buffers, the arbiter and the
// DDR3 controller user port.
interface mem_burst_arbiter_if #(
  parameter int CH_NUM        = 2,
  parameter int MEM_DATA_BITS = 256,
  parameter int ADDR_BITS     = 25,
  parameter int BUSRT_BITS    = 10
);
  logic [CH_NUM-1:0]               ch_rd_burst_req;
  logic [CH_NUM*BUSRT_BITS-1:0]    ch_rd_burst_len;
  logic [CH_NUM*ADDR_BITS-1:0]     ch_rd_burst_addr;
  logic [CH_NUM-1:0]               ch_rd_burst_data_valid;
  logic [MEM_DATA_BITS-1:0]        ch_rd_burst_data;
  logic [CH_NUM-1:0]               ch_rd_burst_finish;
  logic [CH_NUM-1:0]               ch_wr_burst_req;
  logic [CH_NUM*BUSRT_BITS-1:0]    ch_wr_burst_len;
  logic [CH_NUM*ADDR_BITS-1:0]     ch_wr_burst_addr;
  logic [CH_NUM-1:0]               ch_wr_burst_data_req;
  logic [CH_NUM*MEM_DATA_BITS-1:0] ch_wr_burst_data;
  logic [CH_NUM-1:0]               ch_wr_burst_finish;

  logic                            rd_burst_req;
  logic [BUSRT_BITS-1:0]           rd_burst_len;
  logic [ADDR_BITS-1:0]            rd_burst_addr;
  logic                            rd_burst_data_valid;
  logic [MEM_DATA_BITS-1:0]        rd_burst_data;
  logic                            rd_burst_finish;
  logic                            wr_burst_req;
  logic [BUSRT_BITS-1:0]           wr_burst_len;
  logic [ADDR_BITS-1:0]            wr_burst_addr;
  logic                            wr_burst_data_req;
  logic [MEM_DATA_BITS-1:0]        wr_burst_data;
  logic                            wr_burst_finish;
  logic                            arb_busy;

  modport master (
    input  ch_rd_burst_req, ch_rd_burst_len, ch_rd_burst_addr,
    output ch_rd_burst_data_valid, ch_rd_burst_data,
    output ch_rd_burst_finish,
    input  ch_wr_burst_req, ch_wr_burst_len, ch_wr_burst_addr,
    output ch_wr_burst_data_req,
    input  ch_wr_burst_data,
    output ch_wr_burst_finish,
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    input  rd_burst_data_valid, rd_burst_data, rd_burst_finish,
    output wr_burst_req, wr_burst_len, wr_burst_addr,
    input  wr_burst_data_req, wr_burst_finish,
    output wr_burst_data,
    output arb_busy
  );

  modport slave (
    output ch_rd_burst_req, ch_rd_burst_len, ch_rd_burst_addr,
    input  ch_rd_burst_data_valid, ch_rd_burst_data,
    input  ch_rd_burst_finish,
    output ch_wr_burst_req, ch_wr_burst_len, ch_wr_burst_addr,
    input  ch_wr_burst_data_req,
    output ch_wr_burst_data,
    input  ch_wr_burst_finish,
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    output rd_burst_data_valid, rd_burst_data, rd_burst_finish,
    input  wr_burst_req, wr_burst_len, wr_burst_addr,
    output wr_burst_data_req, wr_burst_finish,
    input  wr_burst_data,
    input  arb_busy
  );
endinterface

// File: rtl/mem_burst_arbiter.sv
// Round-robin burst arbiter sharing one DDR3 user port between
// the read and write requesters of CH_NUM frame channels.
module mem_burst_arbiter #(
  parameter int CH_NUM        = 2,
  parameter int MEM_DATA_BITS = 256,
  parameter int ADDR_BITS     = 25,
  parameter int BUSRT_BITS    = 10
) (
  input logic                mem_clk,
  input logic                rst,
  mem_burst_arbiter_if.master bus
);
  localparam int SLOTS = 2 * CH_NUM;
  localparam int SW    = $clog2(SLOTS);
  localparam logic [SW:0]   NSLOT = (SW+1)'(SLOTS);
  localparam logic [SW-1:0] LAST  = SW'(SLOTS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state;
  logic [SW-1:0]          rr_ptr;
  logic [SW-1:0]          grant;
  logic                   zero_len;
  logic                   rd_req;
  logic                   wr_req;
  logic [BUSRT_BITS-1:0]  rd_len;
  logic [BUSRT_BITS-1:0]  wr_len;
  logic [ADDR_BITS-1:0]   rd_addr;
  logic [ADDR_BITS-1:0]   wr_addr;

  logic [SLOTS-1:0]       req;
  logic [SW:0]            cand;
  logic [SW-1:0]          pick;
  logic                   found;
  int                     pch;
  int                     gch;
  logic [BUSRT_BITS-1:0]  pick_len;
  logic [ADDR_BITS-1:0]   pick_addr;
  logic                   ctl_fin;

  logic [CH_NUM-1:0]      rd_valid_o;
  logic [CH_NUM-1:0]      rd_fin_o;
  logic [CH_NUM-1:0]      wr_dreq_o;
  logic [CH_NUM-1:0]      wr_fin_o;

  always_comb begin
    req = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      req[2*k]   = bus.ch_wr_burst_req[k];
      req[2*k+1] = bus.ch_rd_burst_req[k];
    end
  end

  // first requesting slot at or after rr_ptr, wrapping
  always_comb begin
    cand  = '0;
    found = 1'b0;
    pick  = rr_ptr;
    for (int i = 0; i < SLOTS; i++) begin
      cand = {1'b0, rr_ptr} + (SW+1)'(i);
      if (cand >= NSLOT) cand = cand - NSLOT;
      if (!found && req[cand[SW-1:0]]) begin
        found = 1'b1;
        pick  = cand[SW-1:0];
      end
    end
  end

  assign pch = int'(pick >> 1);
  assign gch = int'(grant >> 1);

  always_comb begin
    pick_len  = '0;
    pick_addr = '0;
    if (pick[0]) begin
      pick_len  = bus.ch_rd_burst_len[pch*BUSRT_BITS +: BUSRT_BITS];
      pick_addr = bus.ch_rd_burst_addr[pch*ADDR_BITS +: ADDR_BITS];
    end else begin
      pick_len  = bus.ch_wr_burst_len[pch*BUSRT_BITS +: BUSRT_BITS];
      pick_addr = bus.ch_wr_burst_addr[pch*ADDR_BITS +: ADDR_BITS];
    end
  end

  assign ctl_fin = grant[0] ? bus.rd_burst_finish
                            : bus.wr_burst_finish;

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      zero_len <= 1'b0;
      rd_req   <= 1'b0;
      wr_req   <= 1'b0;
      rd_len   <= '0;
      wr_len   <= '0;
      rd_addr  <= '0;
      wr_addr  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant    <= pick;
            rr_ptr   <= (pick == LAST) ? '0 : pick + 1'b1;
            zero_len <= (pick_len == '0);
            if (pick[0]) begin
              rd_len  <= pick_len;
              rd_addr <= pick_addr;
              rd_req  <= (pick_len != '0);
            end else begin
              wr_len  <= pick_len;
              wr_addr <= pick_addr;
              wr_req  <= (pick_len != '0);
            end
            state <= BUSY;
          end
        end
        BUSY: begin
          if (zero_len || ctl_fin) begin
            rd_req <= 1'b0;
            wr_req <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // only the granted slot sees controller handshakes
  always_comb begin
    rd_valid_o = '0;
    rd_fin_o   = '0;
    wr_dreq_o  = '0;
    wr_fin_o   = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (state == BUSY && gch == k) begin
        if (grant[0]) begin
          rd_valid_o[k] = bus.rd_burst_data_valid & ~zero_len;
          rd_fin_o[k]   = zero_len | bus.rd_burst_finish;
        end else begin
          wr_dreq_o[k]  = bus.wr_burst_data_req & ~zero_len;
          wr_fin_o[k]   = zero_len | bus.wr_burst_finish;
        end
      end
    end
  end

  assign bus.ch_rd_burst_data_valid = rd_valid_o;
  assign bus.ch_rd_burst_finish     = rd_fin_o;
  assign bus.ch_wr_burst_data_req   = wr_dreq_o;
  assign bus.ch_wr_burst_finish     = wr_fin_o;
  assign bus.ch_rd_burst_data       = bus.rd_burst_data;
  assign bus.wr_burst_data          =
    bus.ch_wr_burst_data[gch*MEM_DATA_BITS +: MEM_DATA_BITS];

  assign bus.rd_burst_req  = rd_req;
  assign bus.rd_burst_len  = rd_len;
  assign bus.rd_burst_addr = rd_addr;
  assign bus.wr_burst_req  = wr_req;
  assign bus.wr_burst_len  = wr_len;
  assign bus.wr_burst_addr = wr_addr;
  assign bus.arb_busy      = (state != IDLE);
endmodule
